// File: rtl/mem_map_ctrl_if.sv
// CPU-side bus bundle for the programmable memory-map controller.
// The master drives address/strobes; the slave (controller) returns chip selects and READY.
interface mem_map_ctrl_if #(
   parameter int ADDR_W      = 16,
   parameter int NUM_REGIONS = 4
);
   localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   logic                   ale;
   logic [ADDR_W-1:0]      address;
   logic                   IOMn;
   logic                   RDn;
   logic                   WRn;
   logic [NUM_REGIONS-1:0] CSn;
   logic                   ready;
   logic [IDX_W-1:0]       hit_idx;
   logic                   bus_err;

   modport master (
      output ale, address, IOMn, RDn, WRn,
      input  CSn, ready, hit_idx, bus_err
   );

   modport slave (
      input  ale, address, IOMn, RDn, WRn,
      output CSn, ready, hit_idx, bus_err
   );
endinterface

// File: rtl/mem_map_ctrl.sv
// Programmable address decoder and READY wait-state generator for an 8085-class bus.
// Decode is captured on ALE; a rising strobe edge then starts one access in the FSM.
module mem_map_ctrl #(
   parameter int                            ADDR_W      = 16,
   parameter int                            NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'h0300, 16'h0200, 16'h0100, 16'h0000},
   parameter logic [NUM_REGIONS*5-1:0]      REGION_LOG2 = {5'd8, 5'd8, 5'd8, 5'd8},
   parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT = {4'd0, 4'd3, 4'd1, 4'd0}
) (
   input logic           clk,
   input logic           rst,
   mem_map_ctrl_if.slave bus
);
   localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   bus_err_q, bus_err_d;
   logic [NUM_REGIONS-1:0] csn_q, csn_d;
   logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
   logic                   iom_q, iom_d;
   logic                   hit_q, hit_d;
   logic [3:0]             wait_q, wait_d;
   logic                   strb_q, strb_d;

   logic                   strb_s;
   logic                   start_s;
   logic                   dec_hit_s;
   logic [IDX_W-1:0]       dec_idx_s;
   logic [3:0]             dec_wait_s;

   assign strb_s  = ~bus.RDn | ~bus.WRn;
   // ALE in the same cycle swallows the start; the strobe must fall and rise again.
   assign start_s = strb_s & ~strb_q & ~bus.ale;
   assign strb_d  = strb_s;

   // Region match on the live address; descending scan leaves the lowest hitting index.
   always_comb begin
      dec_hit_s  = 1'b0;
      dec_idx_s  = {IDX_W{1'b0}};
      dec_wait_s = 4'd0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((bus.address >> REGION_LOG2[i*5 +: 5]) ==
             (REGION_BASE[i*ADDR_W +: ADDR_W] >> REGION_LOG2[i*5 +: 5])) begin
            dec_hit_s  = 1'b1;
            dec_idx_s  = IDX_W'(i);
            dec_wait_s = REGION_WAIT[i*4 +: 4];
         end else begin
            dec_hit_s  = dec_hit_s;
         end
      end
   end

   // Capture decode result on ALE; held until the next ALE.
   always_comb begin
      csn_d     = csn_q;
      hit_idx_d = hit_idx_q;
      iom_d     = iom_q;
      hit_d     = hit_q;
      wait_d    = wait_q;
      if (bus.ale) begin
         iom_d     = bus.IOMn;
         hit_d     = dec_hit_s & ~bus.IOMn;
         csn_d     = {NUM_REGIONS{1'b1}};
         if (dec_hit_s && !bus.IOMn) begin
            csn_d[dec_idx_s] = 1'b0;
            hit_idx_d        = dec_idx_s;
            wait_d           = dec_wait_s;
         end else begin
            hit_idx_d        = {IDX_W{1'b0}};
            wait_d           = 4'd0;
         end
      end else begin
         csn_d = csn_q;
      end
   end

   // Access sequencer: wait-state countdown, unmapped-access error, strobe release tracking.
   always_comb begin
      state_d   = state_q;
      ready_d   = ready_q;
      cnt_d     = cnt_q;
      bus_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (start_s) begin
               if (iom_q) begin
                  state_d = ST_HOLD;
               end else if (!hit_q) begin
                  bus_err_d = 1'b1;
                  state_d   = ST_HOLD;
               end else if (wait_q != 4'd0) begin
                  ready_d = 1'b0;
                  cnt_d   = wait_q - 4'd1;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_HOLD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!strb_s) begin
               ready_d = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               ready_d = 1'b1;
               state_d = ST_HOLD;
            end else begin
               cnt_d   = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            ready_d = 1'b1;
            if (!strb_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // All state and outputs; reset aborts any access in flight without flagging an error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         cnt_q     <= 4'd0;
         bus_err_q <= 1'b0;
         csn_q     <= {NUM_REGIONS{1'b1}};
         hit_idx_q <= {IDX_W{1'b0}};
         iom_q     <= 1'b0;
         hit_q     <= 1'b0;
         wait_q    <= 4'd0;
         strb_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
         csn_q     <= csn_d;
         hit_idx_q <= hit_idx_d;
         iom_q     <= iom_d;
         hit_q     <= hit_d;
         wait_q    <= wait_d;
         strb_q    <= strb_d;
      end
   end

   assign bus.CSn     = csn_q;
   assign bus.ready   = ready_q;
   assign bus.hit_idx = hit_idx_q;
   assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_mem_map_ctrl.sv
// Bench for mem_map_ctrl: default map instance plus an overlapping-region instance,
// driven in lockstep and compared against a region-table reference model.
module tb_mem_map_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        ale, iomn, rdn, wrn;
   logic [15:0] address;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_map_ctrl_if #(.ADDR_W(16), .NUM_REGIONS(4)) bus1 ();
   mem_map_ctrl_if #(.ADDR_W(16), .NUM_REGIONS(4)) bus2 ();

   assign bus1.ale = ale;  assign bus1.address = address;  assign bus1.IOMn = iomn;
   assign bus1.RDn = rdn;  assign bus1.WRn = wrn;
   assign bus2.ale = ale;  assign bus2.address = address;  assign bus2.IOMn = iomn;
   assign bus2.RDn = rdn;  assign bus2.WRn = wrn;

   mem_map_ctrl #(.ADDR_W(16), .NUM_REGIONS(4)) u_dut (.clk(clk), .rst(rst), .bus(bus1));

   mem_map_ctrl #(
      .ADDR_W(16), .NUM_REGIONS(4),
      .REGION_BASE({16'h0300, 16'h0200, 16'h0000, 16'h0000}),
      .REGION_LOG2({5'd8, 5'd8, 5'd9, 5'd8}),
      .REGION_WAIT({4'd0, 4'd3, 4'd1, 4'd0})
   ) u_dut_ovl (.clk(clk), .rst(rst), .bus(bus2));

   logic [3:0] o_csn [2];
   logic [1:0] o_idx [2];
   logic       o_rdy [2];
   logic       o_err [2];
   assign o_csn[0] = bus1.CSn;  assign o_idx[0] = bus1.hit_idx;
   assign o_rdy[0] = bus1.ready; assign o_err[0] = bus1.bus_err;
   assign o_csn[1] = bus2.CSn;  assign o_idx[1] = bus2.hit_idx;
   assign o_rdy[1] = bus2.ready; assign o_err[1] = bus2.bus_err;

   // Region tables of the two instances, index = region number.
   int base_cfg [2][4] = '{'{'h0000, 'h0100, 'h0200, 'h0300}, '{'h0000, 'h0000, 'h0200, 'h0300}};
   int log_cfg  [2][4] = '{'{8, 8, 8, 8}, '{8, 9, 8, 8}};
   int wait_cfg [4]    = '{0, 1, 3, 0};

   function automatic void model_decode(input int cfg, input int a, input bit io,
                                        output logic [3:0] csn, output int idx,
                                        output int w, output bit unmapped);
      bit found;
      int sz;
      found = 1'b0; csn = 4'hF; idx = 0; w = 0; unmapped = 1'b0;
      if (!io) begin
         for (int i = 0; i < 4; i++) begin
            sz = 1 << log_cfg[cfg][i];
            if (!found && (a / sz) == (base_cfg[cfg][i] / sz)) begin
               found = 1'b1; idx = i; w = wait_cfg[i]; csn[i] = 1'b0;
            end
         end
         unmapped = !found;
      end
   endfunction

   // One full access: ALE decode, optional idle gap, strobe held 'hold' cycles, then release.
   task automatic test_access(input logic [15:0] a, input bit io, input int rw,
                              input int hold, input int gap, input string name);
      logic [3:0] e_csn [2];
      int         e_idx [2], e_w [2], lowc;
      bit         e_unm [2];
      logic       e_rdy, e_err;
      for (int d = 0; d < 2; d++) model_decode(d, a, io, e_csn[d], e_idx[d], e_w[d], e_unm[d]);
      ale = 1'b1; address = a; iomn = io;
      @(posedge clk); #1;
      ale = 1'b0; address = 16'($urandom); iomn = 1'($urandom);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (o_csn[d] !== e_csn[d] || o_idx[d] !== 2'(e_idx[d])) begin
            errors++;
            $display("FAIL %s decode dut%0d addr=%h io=%0d: CSn=%b hit_idx=%0d expected CSn=%b hit_idx=%0d",
                     name, d, a, io, o_csn[d], o_idx[d], e_csn[d], e_idx[d]);
         end
      end
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_csn[d] !== e_csn[d] || o_rdy[d] !== 1'b1 || o_err[d] !== 1'b0) begin
               errors++;
               $display("FAIL %s gap dut%0d: CSn=%b ready=%b bus_err=%b expected CSn=%b ready=1 bus_err=0",
                        name, d, o_csn[d], o_rdy[d], o_err[d], e_csn[d]);
            end
         end
      end
      if (rw == 0) rdn = 1'b0;
      else if (rw == 1) wrn = 1'b0;
      else begin rdn = 1'b0; wrn = 1'b0; end
      for (int k = 0; k <= hold + 1; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            lowc  = (e_w[d] < hold) ? e_w[d] : hold;
            e_rdy = (k < lowc) ? 1'b0 : 1'b1;
            e_err = (k == 0 && e_unm[d]) ? 1'b1 : 1'b0;
            checks++;
            if (o_rdy[d] !== e_rdy || o_err[d] !== e_err || o_csn[d] !== e_csn[d]) begin
               errors++;
               $display("FAIL %s access dut%0d addr=%h k=%0d: ready=%b bus_err=%b CSn=%b expected ready=%b bus_err=%b CSn=%b",
                        name, d, a, k, o_rdy[d], o_err[d], o_csn[d], e_rdy, e_err, e_csn[d]);
            end
         end
         if (k == hold - 1) begin rdn = 1'b1; wrn = 1'b1; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         ale = 1'($urandom); address = 16'($urandom); iomn = 1'($urandom);
         rdn = 1'($urandom); wrn = 1'($urandom);
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (o_csn[d] !== 4'hF || o_rdy[d] !== 1'b1 || o_err[d] !== 1'b0 || o_idx[d] !== 2'd0) begin
               errors++;
               $display("FAIL reset dut%0d cyc%0d: CSn=%b ready=%b bus_err=%b hit_idx=%0d expected F/1/0/0",
                        d, c, o_csn[d], o_rdy[d], o_err[d], o_idx[d]);
            end
         end
      end
      ale = 1'b0; address = 16'h0000; iomn = 1'b0; rdn = 1'b1; wrn = 1'b1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Strobe starting together with ALE must not begin an access.
   task automatic test_ale_priority();
      ale = 1'b1; address = 16'h0210; iomn = 1'b0; rdn = 1'b0;
      @(posedge clk); #1;
      ale = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bus1.ready !== 1'b1 || bus1.bus_err !== 1'b0 || bus1.CSn !== 4'b1011) begin
            errors++;
            $display("FAIL ale_priority k=%0d: ready=%b bus_err=%b CSn=%b expected 1/0/1011",
                     k, bus1.ready, bus1.bus_err, bus1.CSn);
         end
      end
      rdn = 1'b1;
      @(posedge clk); #1;
   endtask

   // ALE during wait states re-decodes but the access keeps its original wait count.
   task automatic test_ale_in_wait();
      logic e_rdy;
      ale = 1'b1; address = 16'h0220; iomn = 1'b0;
      @(posedge clk); #1;
      ale = 1'b0; wrn = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         ale = 1'b0;
         e_rdy = (k < 3) ? 1'b0 : 1'b1;
         checks++;
         if (bus1.ready !== e_rdy || bus1.bus_err !== 1'b0 ||
             (k >= 1 && (bus1.CSn !== 4'b1110 || bus1.hit_idx !== 2'd0))) begin
            errors++;
            $display("FAIL ale_in_wait k=%0d: ready=%b bus_err=%b CSn=%b hit_idx=%0d expected ready=%b",
                     k, bus1.ready, bus1.bus_err, bus1.CSn, bus1.hit_idx, e_rdy);
         end
         if (k == 0) begin ale = 1'b1; address = 16'h0042; end
         if (k == 3) wrn = 1'b1;
      end
   endtask

   task automatic test_reset_mid_access();
      ale = 1'b1; address = 16'h0230; iomn = 1'b0;
      @(posedge clk); #1;
      ale = 1'b0; rdn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus1.ready !== 1'b0) begin
         errors++; $display("FAIL reset_mid wait_entry: ready=%b expected 0", bus1.ready);
      end
      rst = 1'b1; rdn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus1.ready !== 1'b1 || bus1.CSn !== 4'hF || bus1.bus_err !== 1'b0 || bus1.hit_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid abort: ready=%b CSn=%b bus_err=%b hit_idx=%0d expected 1/F/0/0",
                  bus1.ready, bus1.CSn, bus1.bus_err, bus1.hit_idx);
      end
      rst = 1'b0;
      ale = 1'b1; address = 16'h8000;
      @(posedge clk); #1;
      ale = 1'b0; rdn = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus1.bus_err !== 1'b0 || bus2.bus_err !== 1'b0) begin
         errors++; $display("FAIL reset_mid no_err: bus_err=%b/%b expected 0/0", bus1.bus_err, bus2.bus_err);
      end
      rdn = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus1.bus_err !== 1'b0 || bus1.ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid release: bus_err=%b ready=%b expected 0/1", bus1.bus_err, bus1.ready);
      end
   endtask

   task automatic test_random(input int n);
      logic [15:0] a;
      for (int t = 0; t < n; t++) begin
         a = ($urandom_range(0, 3) == 3) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF));
         test_access(a, ($urandom_range(0, 4) == 0), $urandom_range(0, 2),
                     $urandom_range(1, 6), $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      rst = 1'b1; ale = 1'b0; address = 16'h0000; iomn = 1'b0; rdn = 1'b1; wrn = 1'b1;
      test_reset();
      test_access(16'h0042, 1'b0, 0, 3, 0, "region0_read");
      checks++;
      if (bus1.CSn !== 4'b1110 || bus1.hit_idx !== 2'd0) begin
         errors++; $display("FAIL region0_const: CSn=%b hit_idx=%0d expected 1110/0", bus1.CSn, bus1.hit_idx);
      end
      test_access(16'h0210, 1'b0, 1, 5, 0, "region2_write");
      checks++;
      if (bus1.CSn !== 4'b1011 || bus1.hit_idx !== 2'd2) begin
         errors++; $display("FAIL region2_const: CSn=%b hit_idx=%0d expected 1011/2", bus1.CSn, bus1.hit_idx);
      end
      test_access(16'h8000, 1'b0, 0, 2, 1, "unmapped");
      checks++;
      if (bus1.CSn !== 4'hF) begin
         errors++; $display("FAIL unmapped_const: CSn=%b expected 1111", bus1.CSn);
      end
      test_access(16'h0150, 1'b0, 0, 1, 0, "region1_short");
      test_access(16'h0280, 1'b0, 0, 1, 0, "region2_abort");
      test_access(16'h0281, 1'b0, 1, 4, 0, "after_abort");
      test_access(16'h0100, 1'b1, 0, 2, 0, "io_cycle");
      checks++;
      if (bus1.CSn !== 4'hF) begin
         errors++; $display("FAIL io_const: CSn=%b expected 1111", bus1.CSn);
      end
      test_access(16'h0010, 1'b0, 0, 2, 0, "overlap");
      checks++;
      if (bus2.CSn !== 4'b1110 || bus2.hit_idx !== 2'd0) begin
         errors++; $display("FAIL overlap_const: CSn=%b hit_idx=%0d expected 1110/0", bus2.CSn, bus2.hit_idx);
      end
      test_access(16'h01F0, 1'b0, 2, 3, 0, "rd_wr_both");
      test_access(16'h03FF, 1'b0, 2, 2, 0, "region3_edge");
      test_access(16'h0400, 1'b0, 0, 2, 0, "above_map");
      test_ale_priority();
      test_ale_in_wait();
      test_reset_mid_access();
      test_random(40);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
